if_id_skid_reg: RTL and testbench

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

---
 rtl/if_id_skid_reg.sv | 128 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer and registered in_ready.
// Optional back-pressure cycle counter is enabled by defining PIPE_STALL_CNT_EN.
module if_id_skid_reg #(
    parameter int INSTR_W     = 32,
    parameter int ADDR_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_W-1:0]     instruction_in,
    input  logic [ADDR_W-1:0]      PCNext4_in,
    input  logic [ADDR_W-1:0]      PCNow_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_W-1:0]     instruction_out,
    output logic [ADDR_W-1:0]      PCNext4_out,
    output logic [ADDR_W-1:0]      PCNow_out
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int ENTRY_W = INSTR_W + 2 * ADDR_W;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t             state_q, state_d;
    logic [ENTRY_W-1:0] main_q, main_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic [ENTRY_W-1:0] in_entry;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    assign in_entry = {instruction_in, PCNext4_in, PCNow_in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // in_ready is only ever 1 outside FULL, so in_valid alone marks an input transfer here.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_valid && out_ready) begin
                    main_d = in_entry;
                end else if (in_valid) begin
                    skid_d  = in_entry;
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    // Handshake flags are decoded from the next state so they leave the stage as flops.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {instruction_out, PCNext4_out, PCNow_out} = main_q;

`ifdef PIPE_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: directed traffic, flush, async reset and,
// when PIPE_STALL_CNT_EN is defined, stall counter saturation.
`timescale 1ns/1ps
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic [31:0] PCNext4_in;
    logic [31:0] PCNow_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [31:0] PCNext4_out;
    logic [31:0] PCNow_out;
`ifdef PIPE_STALL_CNT_EN
    logic [3:0]  stall_cnt;
    logic [3:0]  exp_stall;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [95:0] sb_q[$];
    int          mon_sz;
    logic        mon_acc;

    always #10 clk = ~clk;

    if_id_skid_reg #(
        .INSTR_W    (32),
        .ADDR_W     (32),
        .STALL_CNT_W(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .instruction_in (instruction_in),
        .PCNext4_in     (PCNext4_in),
        .PCNow_in       (PCNow_in),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .instruction_out(instruction_out),
        .PCNext4_out    (PCNext4_out),
        .PCNow_out      (PCNow_out)
`ifdef PIPE_STALL_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    task automatic check_output(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [31:0] pn4,
                                  input logic [31:0] pc, input logic ordy, input logic fl);
        @(posedge clk);
        #2;
        in_valid       = v;
        instruction_in = ins;
        PCNext4_in     = pn4;
        PCNow_in       = pc;
        out_ready      = ordy;
        flush          = fl;
    endtask

    // Monitor: the queue holds every accepted entry in order; its size predicts the handshake flags.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            sb_q.delete();
`ifdef PIPE_STALL_CNT_EN
            exp_stall = 4'd0;
`endif
        end else begin
            mon_sz = sb_q.size();
            check_output("out_valid", 96'(out_valid), 96'(mon_sz > 0));
            check_output("in_ready", 96'(in_ready), 96'(mon_sz < 2));
            if (mon_sz > 0) begin
                check_output("out_data", {instruction_out, PCNext4_out, PCNow_out}, sb_q[0]);
            end
`ifdef PIPE_STALL_CNT_EN
            check_output("stall_cnt", 96'(stall_cnt), 96'(exp_stall));
`endif
            if (flush) begin
                sb_q.delete();
            end else begin
                mon_acc = in_valid && (mon_sz < 2);
                if (mon_sz > 0 && out_ready) begin
                    void'(sb_q.pop_front());
                end
                if (mon_acc) begin
                    sb_q.push_back({instruction_in, PCNext4_in, PCNow_in});
                end
`ifdef PIPE_STALL_CNT_EN
                if (mon_sz > 0 && !out_ready && exp_stall != 4'hF) begin
                    exp_stall = exp_stall + 4'd1;
                end
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset          = 1'b0;
        flush          = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        instruction_in = '0;
        PCNext4_in     = '0;
        PCNow_in       = '0;

        repeat (2) @(negedge clk);
        check_output("rst_in_ready", 96'(in_ready), 96'(1));
        check_output("rst_out_valid", 96'(out_valid), 96'(0));
        check_output("rst_instr", 96'(instruction_out), 96'(0));
        check_output("rst_pcnext4", 96'(PCNext4_out), 96'(0));
        check_output("rst_pcnow", 96'(PCNow_out), 96'(0));
        @(posedge clk);
        #2 reset = 1'b1;

        // Single entry, one-cycle latency
        apply_stimulus(1'b1, 32'h20080005, 32'h4, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_output("lat_valid", 96'(out_valid), 96'(1));
        check_output("lat_instr", 96'(instruction_out), 96'(32'h20080005));
        check_output("lat_pcnext4", 96'(PCNext4_out), 96'(32'h4));
        check_output("lat_pcnow", 96'(PCNow_out), 96'(32'h0));
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Back-pressure: A, B fill the stage, C waits until space frees up
        apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFC, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h00000013, 32'h00000008, 32'h00000004, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'hDEADBEEF, 32'hCAFE0004, 32'hCAFE0000, 1'b0, 1'b0);
        @(negedge clk);
        check_output("full_in_ready", 96'(in_ready), 96'(0));
        check_output("full_head", 96'(instruction_out), 96'(32'hFFFFFFFF));
        apply_stimulus(1'b1, 32'hDEADBEEF, 32'hCAFE0004, 32'hCAFE0000, 1'b1, 1'b0);
        apply_stimulus(1'b1, 32'hDEADBEEF, 32'hCAFE0004, 32'hCAFE0000, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush while full with a simultaneous input
        apply_stimulus(1'b1, 32'h11111111, 32'h00000104, 32'h00000100, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h22222222, 32'h00000108, 32'h00000104, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h33333333, 32'h0000010C, 32'h00000108, 1'b1, 1'b1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("flush_valid", 96'(out_valid), 96'(0));
        check_output("flush_instr", 96'(instruction_out), 96'(0));
        check_output("flush_pcnow", 96'(PCNow_out), 96'(0));
        check_output("flush_in_ready", 96'(in_ready), 96'(1));

        // Asynchronous reset while full
        apply_stimulus(1'b1, 32'h44444444, 32'h00000204, 32'h00000200, 1'b0, 1'b0);
        apply_stimulus(1'b1, 32'h55555555, 32'h00000208, 32'h00000204, 1'b0, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_output("arst_valid", 96'(out_valid), 96'(0));
        check_output("arst_in_ready", 96'(in_ready), 96'(1));
        check_output("arst_instr", 96'(instruction_out), 96'(0));
        check_output("arst_pcnext4", 96'(PCNext4_out), 96'(0));
        check_output("arst_pcnow", 96'(PCNow_out), 96'(0));
`ifdef PIPE_STALL_CNT_EN
        check_output("arst_stall", 96'(stall_cnt), 96'(0));
`endif
        #1 reset = 1'b1;
        apply_stimulus(1'b1, 32'h66666666, 32'h00000304, 32'h00000300, 1'b1, 1'b0);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_output("post_rst_instr", 96'(instruction_out), 96'(32'h66666666));
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

`ifdef PIPE_STALL_CNT_EN
        // Stall counter saturates and survives a flush
        apply_stimulus(1'b1, 32'h77777777, 32'h00000404, 32'h00000400, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check_output("stall_sat", 96'(stall_cnt), 96'(15));
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("stall_flush", 96'(stall_cnt), 96'(15));
        check_output("stall_flush_valid", 96'(out_valid), 96'(0));
`endif

        apply_stimulus(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
